rv32i_datapath_units: RTL and testbench

// - Execution-resource block of the rv32i multicycle core: PC/PC_old register pair, 32x32 register file, combinational ALU.
// - Wraps three sub-blocks (generic enabled register, register file, behavioural ALU) behind one interface.
// - The core FSM drives all selects and enables; this block holds no control state.

---
 rtl/rv32i_datapath_units_pkg.sv | 38 +++
 rtl/rv32i_datapath_units_if.sv | 48 ++++
 rtl/rv32i_datapath_units_alu.sv | 58 +++++
 rtl/rv32i_datapath_units_register.sv | 27 ++
 rtl/rv32i_datapath_units_register_file.sv | 39 +++
 rtl/rv32i_datapath_units.sv | 53 +++++
 tb/tb_rv32i_datapath_units.sv | 277 +++++++++++++++++++++++++++
 7 files changed

// File: rtl/rv32i_datapath_units_pkg.sv
// Shared types for the rv32i datapath units.
// Contents:
//   alu_control_t      4-bit ALU operation select driven by the core FSM
//   alu_control_name() readable operation name for debug displays
package alu_types;

    typedef enum logic [3:0] {
        ALU_INVALID = 4'b0000,
        ALU_AND     = 4'b0001,
        ALU_OR      = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_ADD     = 4'b1000,
        ALU_SUB     = 4'b1100,
        ALU_SLT     = 4'b1101,
        ALU_SLTU    = 4'b1111
    } alu_control_t;

    function automatic string alu_control_name(alu_control_t control);
        case (control)
            ALU_INVALID: return "INVALID";
            ALU_AND:     return "AND";
            ALU_OR:      return "OR";
            ALU_XOR:     return "XOR";
            ALU_SLL:     return "SLL";
            ALU_SRL:     return "SRL";
            ALU_SRA:     return "SRA";
            ALU_ADD:     return "ADD";
            ALU_SUB:     return "SUB";
            ALU_SLT:     return "SLT";
            ALU_SLTU:    return "SLTU";
            default:     return "UNDEFINED";
        endcase
    endfunction

endpackage

// File: rtl/rv32i_datapath_units_if.sv
// Bundle between the core FSM (master) and the datapath units (slave).
// Signals:
//   pc_ena, pc_next -> pc, pc_old                     PC register pair
//   rf_wr_*, rf_rd_addr0/1 -> rf_rd_data0/1            register file
//   alu_a, alu_b, alu_control -> alu_result and flags  ALU
interface rv32i_datapath_units_if;
    import alu_types::*;

    logic         pc_ena;
    logic [31:0]  pc_next;
    logic [31:0]  pc;
    logic [31:0]  pc_old;

    logic         rf_wr_ena;
    logic [4:0]   rf_wr_addr;
    logic [31:0]  rf_wr_data;
    logic [4:0]   rf_rd_addr0;
    logic [4:0]   rf_rd_addr1;
    logic [31:0]  rf_rd_data0;
    logic [31:0]  rf_rd_data1;

    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    alu_control_t alu_control;
    logic [31:0]  alu_result;
    logic         alu_overflow;
    logic         alu_zero;
    logic         alu_equal;

    modport master (
        output pc_ena, pc_next,
        input  pc, pc_old,
        output rf_wr_ena, rf_wr_addr, rf_wr_data, rf_rd_addr0, rf_rd_addr1,
        input  rf_rd_data0, rf_rd_data1,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_overflow, alu_zero, alu_equal
    );

    modport slave (
        input  pc_ena, pc_next,
        output pc, pc_old,
        input  rf_wr_ena, rf_wr_addr, rf_wr_data, rf_rd_addr0, rf_rd_addr1,
        output rf_rd_data0, rf_rd_data1,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_overflow, alu_zero, alu_equal
    );

endinterface

// File: rtl/rv32i_datapath_units_alu.sv
// Combinational rv32i ALU.
// Ports:
//   a, b      operands (shifts use b[4:0] only)
//   control   alu_control_t operation select; unlisted codes give 0
//   result    operation result
//   overflow  signed overflow, ADD/SUB only
//   zero      result == 0
//   equal     a == b, independent of control
module alu_behavioural
    import alu_types::*;
(
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  alu_control_t control,
    output logic [31:0]  result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[4:0];

    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned, which would otherwise infer latches.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_ADD: begin
                result   = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            default:  result = '0;
        endcase
    end

    assign zero  = (result == 32'd0);
    assign equal = (a == b);

endmodule

// File: rtl/rv32i_datapath_units_register.sv
// Generic N-bit register with load enable and synchronous active-high reset.
// Ports:
//   clk, rst  clock and reset (reset wins over ena)
//   ena       load enable
//   d, q      data in / registered data out
module register #(
    parameter int            N     = 32,
    parameter logic [N-1:0]  RESET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // NOTE: state is updated with <= so every register samples pre-edge values;
    // this is what lets pc_old capture the pc being replaced on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rv32i_datapath_units_register_file.sv
// 32 x 32-bit register file: one synchronous write port, two combinational
// read ports. x0 is hard-wired to zero.
// Ports:
//   clk, rst              clock and synchronous reset (clears every register)
//   wr_ena, wr_addr, wr_data  write port, takes effect on posedge
//   rd_addr0/1 -> rd_data0/1  read ports, 0-cycle latency, pre-edge contents
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1
);

    logic [31:0] regs [32];

    // NOTE: resetting every entry makes this a flop array rather than an
    // inferable RAM; that is intended, since the core relies on a clean
    // register file after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ena && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write-through bypass: a read of the register being written returns
    // the old contents until the edge.
    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'd0 : regs[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : regs[rd_addr1];

endmodule

// File: rtl/rv32i_datapath_units.sv
// Execution resources of the rv32i multicycle core: PC/PC_old pair,
// 32x32 register file and combinational ALU. Wiring only; all control
// comes from the core FSM through the interface.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       rv32i_datapath_units_if.slave (PC, register file, ALU signals)
module rv32i_datapath_units #(
    parameter logic [31:0] PC_START_ADDRESS = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32i_datapath_units_if.slave bus
);

    register #(.N(32), .RESET(PC_START_ADDRESS)) u_pc (
        .clk (clk),
        .rst (rst),
        .ena (bus.pc_ena),
        .d   (bus.pc_next),
        .q   (bus.pc)
    );

    register #(.N(32), .RESET(32'h0)) u_pc_old (
        .clk (clk),
        .rst (rst),
        .ena (bus.pc_ena),
        .d   (bus.pc),
        .q   (bus.pc_old)
    );

    register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (bus.rf_wr_ena),
        .wr_addr  (bus.rf_wr_addr),
        .wr_data  (bus.rf_wr_data),
        .rd_addr0 (bus.rf_rd_addr0),
        .rd_addr1 (bus.rf_rd_addr1),
        .rd_data0 (bus.rf_rd_data0),
        .rd_data1 (bus.rf_rd_data1)
    );

    alu_behavioural u_alu (
        .a        (bus.alu_a),
        .b        (bus.alu_b),
        .control  (bus.alu_control),
        .result   (bus.alu_result),
        .overflow (bus.alu_overflow),
        .zero     (bus.alu_zero),
        .equal    (bus.alu_equal)
    );

endmodule

// File: tb/tb_rv32i_datapath_units.sv
// Self-checking bench for rv32i_datapath_units: directed PC/regfile
// sequences, a table of ALU vectors, then randomized ALU operations and
// randomized PC/regfile traffic compared against a behavioural model.
module tb_rv32i_datapath_units;
    import alu_types::*;

    localparam logic [31:0] START = 32'h100;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rv32i_datapath_units_if bus ();

    rv32i_datapath_units #(.PC_START_ADDRESS(START)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        logic        eq;
    } alu_vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
    } alu_model_t;

    alu_vec_t    vecs [14];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_pc_old;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU from the operation definitions; overflow comes from
    // whether the exact signed result fits in 32 bits.
    function automatic alu_model_t alu_model(logic [3:0] ctrl, logic [31:0] a, logic [31:0] b);
        alu_model_t m;
        longint sa, sb, exact;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        m.res = 32'd0;
        m.ovf = 1'b0;
        case (ctrl)
            4'b0001: m.res = a & b;
            4'b0010: m.res = a | b;
            4'b0011: m.res = a ^ b;
            4'b0101: m.res = 32'(64'(a) * (64'd1 << sh));
            4'b0110: m.res = a / (32'd1 << sh);
            4'b0111: m.res = 32'(sa >>> sh);
            4'b1000: begin
                exact = sa + sb;
                m.res = 32'(exact);
                m.ovf = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            4'b1100: begin
                exact = sa - sb;
                m.res = 32'(exact);
                m.ovf = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            4'b1101: m.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1111: m.res = (a < b) ? 32'd1 : 32'd0;
            default: m.res = 32'd0;
        endcase
        return m;
    endfunction

    task automatic apply_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        bus.alu_control = alu_control_t'(ctrl);
        bus.alu_a       = a;
        bus.alu_b       = b;
        #1;
    endtask

    initial begin
        vecs[0]  = '{4'b1000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b1100, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'b1101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0110, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0101, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b0000, 32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{4'b1100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'b0100, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b1, 1'b0};

        rst             = 1'b1;
        bus.pc_ena      = 1'b0;
        bus.pc_next     = 32'h0;
        bus.rf_wr_ena   = 1'b0;
        bus.rf_wr_addr  = 5'd0;
        bus.rf_wr_data  = 32'h0;
        bus.rf_rd_addr0 = 5'd0;
        bus.rf_rd_addr1 = 5'd0;
        bus.alu_a       = 32'h0;
        bus.alu_b       = 32'h0;
        bus.alu_control = ALU_INVALID;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        bus.rf_rd_addr0 = 5'd5;
        bus.rf_rd_addr1 = 5'd31;
        #1;
        check("reset_pc", bus.pc, START);
        check("reset_pc_old", bus.pc_old, 32'h0);
        check("reset_rd0", bus.rf_rd_data0, 32'h0);
        check("reset_rd1", bus.rf_rd_data1, 32'h0);

        // PC pair load and hold
        bus.pc_ena  = 1'b1;
        bus.pc_next = 32'h104;
        tick();
        check("pc_load", bus.pc, 32'h104);
        check("pc_old_load", bus.pc_old, 32'h100);
        bus.pc_ena  = 1'b0;
        bus.pc_next = 32'h999;
        tick();
        tick();
        check("pc_hold", bus.pc, 32'h104);
        check("pc_old_hold", bus.pc_old, 32'h100);

        // Register file: write, x0 discard, same-cycle old-value read
        bus.rf_wr_ena  = 1'b1;
        bus.rf_wr_addr = 5'd5;
        bus.rf_wr_data = 32'hDEADBEEF;
        tick();
        bus.rf_wr_addr = 5'd0;
        bus.rf_wr_data = 32'h1234;
        bus.rf_rd_addr0 = 5'd5;
        bus.rf_rd_addr1 = 5'd5;
        #1;
        check("rf_write_x5_port0", bus.rf_rd_data0, 32'hDEADBEEF);
        check("rf_write_x5_port1", bus.rf_rd_data1, 32'hDEADBEEF);
        tick();
        bus.rf_wr_ena   = 1'b0;
        bus.rf_rd_addr1 = 5'd0;
        #1;
        check("rf_x0_discard", bus.rf_rd_data1, 32'h0);
        bus.rf_wr_ena  = 1'b1;
        bus.rf_wr_addr = 5'd5;
        bus.rf_wr_data = 32'h1;
        #1;
        check("rf_same_cycle_old", bus.rf_rd_data0, 32'hDEADBEEF);
        tick();
        bus.rf_wr_ena = 1'b0;
        #1;
        check("rf_after_edge_new", bus.rf_rd_data0, 32'h1);

        // ALU directed vectors
        for (int i = 0; i < 14; i++) begin
            apply_alu(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            check($sformatf("alu_vec%0d_%s_result", i, alu_control_name(alu_control_t'(vecs[i].ctrl))),
                  bus.alu_result, vecs[i].res);
            check($sformatf("alu_vec%0d_overflow", i), 32'(bus.alu_overflow), 32'(vecs[i].ovf));
            check($sformatf("alu_vec%0d_zero", i), 32'(bus.alu_zero), 32'(vecs[i].zero));
            check($sformatf("alu_vec%0d_equal", i), 32'(bus.alu_equal), 32'(vecs[i].eq));
        end

        // ALU randomized against the model (all 16 control codes)
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  ctrl;
            logic [31:0] a, b;
            alu_model_t  m;
            ctrl = 4'($urandom_range(0, 15));
            a    = $urandom();
            b    = (i % 8 == 0) ? a : $urandom();
            if (i % 5 == 0) a = {a[31], 31'h7FFFFFFF ^ {31{a[0]}}};
            m = alu_model(ctrl, a, b);
            apply_alu(ctrl, a, b);
            check($sformatf("alu_rand%0d_result", i), bus.alu_result, m.res);
            check($sformatf("alu_rand%0d_overflow", i), 32'(bus.alu_overflow), 32'(m.ovf));
            check($sformatf("alu_rand%0d_zero", i), 32'(bus.alu_zero), 32'(m.res == 32'd0));
            check($sformatf("alu_rand%0d_equal", i), 32'(bus.alu_equal), 32'(a == b));
        end

        // Fill x1..x31, then reset mid-run with every enable asserted
        bus.rf_wr_ena = 1'b1;
        for (int r = 1; r < 32; r++) begin
            bus.rf_wr_addr = 5'(r);
            bus.rf_wr_data = 32'h01010101 * 32'(r) ^ 32'hA5A50000;
            tick();
        end
        bus.rf_rd_addr0 = 5'd31;
        bus.rf_rd_addr1 = 5'd17;
        #1;
        check("rf_fill_x31", bus.rf_rd_data0, 32'h1F1F1F1F ^ 32'hA5A50000);
        check("rf_fill_x17", bus.rf_rd_data1, 32'h11111111 ^ 32'hA5A50000);
        rst            = 1'b1;
        bus.pc_ena     = 1'b1;
        bus.pc_next    = 32'hCAFE0000;
        bus.rf_wr_addr = 5'd9;
        bus.rf_wr_data = 32'hFFFFFFFF;
        tick();
        rst           = 1'b0;
        bus.pc_ena    = 1'b0;
        bus.rf_wr_ena = 1'b0;
        #1;
        check("midrst_pc", bus.pc, START);
        check("midrst_pc_old", bus.pc_old, 32'h0);
        for (int r = 0; r < 32; r++) begin
            bus.rf_rd_addr0 = 5'(r);
            bus.rf_rd_addr1 = 5'(31 - r);
            #1;
            check($sformatf("midrst_rd0_x%0d", r), bus.rf_rd_data0, 32'h0);
            check($sformatf("midrst_rd1_x%0d", 31 - r), bus.rf_rd_data1, 32'h0);
        end

        // Randomized PC/register-file traffic against the model
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_pc     = START;
        m_pc_old = 32'h0;
        for (int i = 0; i < 500; i++) begin
            logic       pe, we;
            logic [4:0] wa;
            pe = 1'($urandom());
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom());
            bus.pc_ena      = pe;
            bus.pc_next     = $urandom();
            bus.rf_wr_ena   = we;
            bus.rf_wr_addr  = wa;
            bus.rf_wr_data  = $urandom();
            bus.rf_rd_addr0 = (i % 4 == 0) ? wa : 5'($urandom());
            bus.rf_rd_addr1 = (i % 6 == 0) ? bus.rf_rd_addr0 : 5'($urandom());
            #1;
            check($sformatf("rand%0d_rd0", i), bus.rf_rd_data0, m_regs[bus.rf_rd_addr0]);
            check($sformatf("rand%0d_rd1", i), bus.rf_rd_data1, m_regs[bus.rf_rd_addr1]);
            check($sformatf("rand%0d_pc", i), bus.pc, m_pc);
            check($sformatf("rand%0d_pc_old", i), bus.pc_old, m_pc_old);
            tick();
            if (we && wa != 5'd0) m_regs[wa] = bus.rf_wr_data;
            if (pe) begin
                m_pc_old = m_pc;
                m_pc     = bus.pc_next;
            end
        end
        bus.rf_wr_ena = 1'b0;
        bus.pc_ena    = 1'b0;
        #1;
        check("final_pc", bus.pc, m_pc);
        check("final_pc_old", bus.pc_old, m_pc_old);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
